// File: rtl/pid_servo_mc_if.sv
// Bus bundle between the position-target generator / PWM generators and
// the multi-channel servo PID.
//   master : drives sample/enable/setpoint/feedback/gains, observes results
//   slave  : the controller (receives stimulus, drives duty/sat/busy/done)
// Packing: channel k occupies [k*IN_W +: IN_W] of setpoint_i/feedback_i and
// [k*DUTY_W +: DUTY_W] of duty_o.
interface pid_servo_mc_if #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned IN_W   = 12,
  parameter int unsigned DUTY_W = 18,
  parameter int unsigned GAIN_W = 16
);
  logic                     sample_i;
  logic                     enable_i;
  logic [N_CH*IN_W-1:0]     setpoint_i;
  logic [N_CH*IN_W-1:0]     feedback_i;
  logic [GAIN_W-1:0]        kp_i;
  logic [GAIN_W-1:0]        ki_i;
  logic [GAIN_W-1:0]        kd_i;
  logic [N_CH*DUTY_W-1:0]   duty_o;
  logic [N_CH-1:0]          sat_o;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    output sample_i, enable_i, setpoint_i, feedback_i, kp_i, ki_i, kd_i,
    input  duty_o, sat_o, busy_o, done_o
  );

  modport slave (
    input  sample_i, enable_i, setpoint_i, feedback_i, kp_i, ki_i, kd_i,
    output duty_o, sat_o, busy_o, done_o
  );
endinterface

// File: rtl/pid_servo_mc.sv
// Time-multiplexed multi-channel PID controller producing hobby-servo PWM
// duty words. One round (started by a sample pulse) walks every channel
// through ERR -> MAC -> UPD, then pulses done for one cycle.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : pid_servo_mc_if.slave (sample/enable/setpoint/feedback/gains in;
//           duty/sat/busy/done out)
module pid_servo_mc #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned IN_W      = 12,
  parameter int unsigned DUTY_W    = 18,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned FRAC_BITS = 0,
  parameter int unsigned INT_W     = 24,
  parameter int unsigned INT_LIM   = 1048576,
  parameter int unsigned MIN_DUTY  = 50000,
  parameter int unsigned OFFSET    = 75000,
  parameter int unsigned MAX_DUTY  = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  pid_servo_mc_if.slave   bus
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned E_W   = IN_W + 1;
  localparam int unsigned D_W   = IN_W + 2;
  localparam int unsigned ACC_W = GAIN_W + INT_W + 3;
  localparam int unsigned V_W   = ACC_W + 1;

  localparam logic signed [INT_W:0]  LIM_P = (INT_W+1)'(INT_LIM);
  localparam logic signed [INT_W:0]  LIM_N = -LIM_P;
  localparam logic signed [V_W-1:0]  OFF_V = V_W'(OFFSET);
  localparam logic signed [V_W-1:0]  MIN_V = V_W'(MIN_DUTY);
  localparam logic signed [V_W-1:0]  MAX_V = V_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0]      OFF_D = DUTY_W'(OFFSET);
  localparam logic [DUTY_W-1:0]      MIN_D = DUTY_W'(MIN_DUTY);
  localparam logic [DUTY_W-1:0]      MAX_D = DUTY_W'(MAX_DUTY);

  typedef enum logic [2:0] {IDLE, ERR, MAC, UPD, DONE} state_t;

  state_t state_q, state_d;
  logic   busy, done, accept, last_ch;

  logic [CH_W-1:0]         ch_q;
  logic [N_CH*IN_W-1:0]    sp_q, fb_q;
  logic [GAIN_W-1:0]       kp_q, ki_q, kd_q;
  logic                    en_q;

  logic signed [INT_W-1:0] integ_q    [N_CH];
  logic signed [E_W-1:0]   last_err_q [N_CH];
  logic [N_CH-1:0]         first_q;

  logic signed [E_W-1:0]   e_q;
  logic signed [D_W-1:0]   d_q;
  logic signed [INT_W-1:0] ic_q;
  logic signed [V_W-1:0]   v_q;

  logic [N_CH*DUTY_W-1:0]  duty_q;
  logic [N_CH-1:0]         sat_q;

  logic [IN_W-1:0]         sp_ch, fb_ch;
  logic signed [E_W-1:0]   e_c;
  logic signed [D_W-1:0]   d_c;
  logic signed [INT_W:0]   isum_c;
  logic signed [INT_W-1:0] ic_c;
  logic signed [ACC_W-1:0] acc_c;
  logic signed [V_W-1:0]   v_c;
  logic [DUTY_W-1:0]       duty_c;
  logic                    over, under, e_pos, e_neg, hold;

  assign accept  = bus.sample_i && ((state_q == IDLE) || (state_q == DONE));
  assign last_ch = (ch_q == CH_W'(N_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = ERR;
      ERR:  begin busy = 1'b1; state_d = MAC; end
      MAC:  begin busy = 1'b1; state_d = UPD; end
      UPD:  begin busy = 1'b1; state_d = last_ch ? DONE : ERR; end
      DONE: begin done = 1'b1; state_d = accept ? ERR : IDLE; end
      default: state_d = IDLE;
    endcase
  end

  // ERR stage: error, derivative and the candidate (saturated) integral.
  // The integral term of this round already includes the current error;
  // anti-windup later decides whether that candidate is committed.
  always_comb begin
    sp_ch  = sp_q[ch_q*IN_W +: IN_W];
    fb_ch  = fb_q[ch_q*IN_W +: IN_W];
    e_c    = $signed({1'b0, sp_ch}) - $signed({1'b0, fb_ch});
    d_c    = first_q[ch_q] ? '0 : (D_W'(e_c) - D_W'(last_err_q[ch_q]));
    isum_c = (INT_W+1)'(integ_q[ch_q]) + (INT_W+1)'(e_c);
    if (isum_c > LIM_P)      ic_c = INT_W'(LIM_P);
    else if (isum_c < LIM_N) ic_c = INT_W'(LIM_N);
    else                     ic_c = INT_W'(isum_c);
  end

  // MAC stage: gains are unsigned, so they are zero-extended before the
  // signed multiply.
  always_comb begin
    acc_c = ACC_W'($signed({1'b0, kp_q})) * ACC_W'(e_q)
          + ACC_W'($signed({1'b0, ki_q})) * ACC_W'(ic_q)
          + ACC_W'($signed({1'b0, kd_q})) * ACC_W'(d_q);
    v_c   = OFF_V + V_W'(acc_c >>> FRAC_BITS);
  end

  // UPD stage: clamp and anti-windup decision.
  always_comb begin
    over   = (v_q > MAX_V);
    under  = (v_q < MIN_V);
    e_pos  = !e_q[E_W-1] && (e_q != '0);
    e_neg  = e_q[E_W-1];
    hold   = (over && e_pos) || (under && e_neg);
    duty_c = over ? MAX_D : (under ? MIN_D : DUTY_W'(v_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      sp_q    <= '0;
      fb_q    <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      kd_q    <= '0;
      en_q    <= 1'b0;
      first_q <= '1;
      e_q     <= '0;
      d_q     <= '0;
      ic_q    <= '0;
      v_q     <= '0;
      duty_q  <= {N_CH{OFF_D}};
      sat_q   <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        integ_q[k]    <= '0;
        last_err_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            sp_q <= bus.setpoint_i;
            fb_q <= bus.feedback_i;
            kp_q <= bus.kp_i;
            ki_q <= bus.ki_i;
            kd_q <= bus.kd_i;
            en_q <= bus.enable_i;
            ch_q <= '0;
          end
        end
        ERR: begin
          e_q  <= e_c;
          d_q  <= d_c;
          ic_q <= ic_c;
        end
        MAC: v_q <= v_c;
        UPD: begin
          if (en_q) begin
            duty_q[ch_q*DUTY_W +: DUTY_W] <= duty_c;
            sat_q[ch_q]      <= over || under;
            last_err_q[ch_q] <= e_q;
            first_q[ch_q]    <= 1'b0;
            if (!hold) integ_q[ch_q] <= ic_q;
          end else begin
            duty_q[ch_q*DUTY_W +: DUTY_W] <= OFF_D;
            sat_q[ch_q]      <= 1'b0;
            last_err_q[ch_q] <= '0;
            first_q[ch_q]    <= 1'b1;
            integ_q[ch_q]    <= '0;
          end
          if (!last_ch) ch_q <= ch_q + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.duty_o = duty_q;
  assign bus.sat_o  = sat_q;
  assign bus.busy_o = busy;
  assign bus.done_o = done;

endmodule

// File: doc/pid_servo_mc.md
Name: pid_servo_mc

Overview:
Multi-channel, time-multiplexed PID controller for hobby-servo PWM duty generation. It is the parametrised successor of the single-channel servo PID. It adds the following:
- runtime gains with fractional scaling
- a sample-strobe update rate
- per-channel integral clamping and anti-windup
- saturation flags
- a start/done handshake

It sits between the position-target generator and the PWM generators. It computes one duty word per servo channel each control period.

Parameters:
N_CH, 2, number of servo channels processed sequentially
IN_W, 12, width of unsigned setpoint/feedback per channel
DUTY_W, 18, width of unsigned duty word per channel
GAIN_W, 16, width of unsigned runtime gains
FRAC_BITS, 0, arithmetic right shift applied to PID sum (gain fixed-point fraction)
INT_W, 24, signed integral accumulator width
INT_LIM, 1048576, integral clamp magnitude (|I| <= INT_LIM)
MIN_DUTY, 50000, duty floor (0 deg)
OFFSET, 75000, centre duty (90 deg), added to PID sum
MAX_DUTY, 100000, duty ceiling (180 deg)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sample_i  in  1  start one control round (pulse)
enable_i  in  1  1 = closed loop; 0 = hold centre, clear loop state
setpoint_i  in  N_CH*IN_W  desired positions, channel k at [k*IN_W +: IN_W]
feedback_i  in  N_CH*IN_W  measured positions, same packing
kp_i  in  GAIN_W  proportional gain (unsigned)
ki_i  in  GAIN_W  integral gain (unsigned)
kd_i  in  GAIN_W  derivative gain (unsigned)
duty_o  out  N_CH*DUTY_W  registered duty words, channel k at [k*DUTY_W +: DUTY_W]
sat_o  out  N_CH  per-channel flag: last computed value was clamped
busy_o  out  1  round in progress
done_o  out  1  one-cycle pulse, all duties of the round updated

Behaviour:
- Reset (async, rst_n=0):
  - every duty_o channel = OFFSET; sat_o = 0; busy_o = 0; done_o = 0.
  - integrals = 0; last_error = 0; first flags = 1; FSM = IDLE.
- FSM states: IDLE, ERR, MAC, UPD, DONE. The channel index ch counts 0..N_CH-1.
- Accept: sample_i=1 in IDLE or DONE at edge T.
  - On accept, snapshot setpoint_i, feedback_i, kp/ki/kd and enable_i.
  - ch := 0; next state is ERR.
  - sample_i in ERR/MAC/UPD is ignored (no queueing).
- ERR:
  - e = signed(IN_W+1) setpoint - feedback.
  - d = e - last_error[ch]. d is forced to 0 if first[ch]=1.
- MAC:
  - acc = kp*e + ki*I[ch] + kd*d, in a signed accumulator wide enough for no overflow (>= GAIN_W+INT_W+2 bits).
  - acc is then arithmetically shifted right by FRAC_BITS.
  - v = OFFSET + acc.
- UPD:
  - duty[ch] = clamp(v, MIN_DUTY, MAX_DUTY); sat_o[ch] = (v>MAX_DUTY)|(v<MIN_DUTY).
  - last_error[ch] = e; first[ch] = 0.
  - Integral I[ch] += e, saturated to ±INT_LIM, with anti-windup: no update if (v>MAX_DUTY and e>0) or (v<MIN_DUTY and e<0).
  - If ch==N_CH-1 go to DONE, else ch++ and go to ERR.
- Timing:
  - ERR ch0 runs in cycle T+1.
  - Channel k UPD runs in cycle T+3k+3; its new duty is visible from T+3k+4.
  - DONE runs in cycle T+3N_CH+1; done_o=1 for exactly that cycle.
  - busy_o=1 in ERR/MAC/UPD only.
  - An unaccepted DONE returns to IDLE.
- enable snapshot = 0: the round still runs with the same timing and done_o still pulses. For every channel in its UPD:
  - duty = OFFSET; sat_o = 0
  - I = 0; last_error = 0; first = 1
- Duty outputs and sat_o change only in UPD (or at reset). Between rounds they hold.
- Reset mid-round: immediate return to reset values. There is no done_o for the aborted round.
- Gains are unsigned. A gain of 0 removes its term.

Test Plan:
- Proportional: N_CH=2, kp=100, ki=kd=0, ch0 sp=1000 fb=900, ch1 sp=900 fb=1000, sample -> duty0=85000, duty1=65000, sat_o=00, done_o in cycle T+7.
- Saturation/anti-windup: kp=100, ki=1, e=+500 for 3 rounds -> duty0=100000, sat_o[0]=1, I0 stays 0 (frozen). Then e=-10 -> I0=-10, duty0=75000-1000-10=73990, sat_o[0]=0.
- Integral: kp=kd=0, ki=1, constant e=+10 over 3 rounds -> duty0 = 75010, 75020, 75030. With INT_LIM=15, the third round gives 75015.
- Derivative: kp=ki=0, kd=10, first round e=50 -> duty0=75000 (d forced 0); second round e=60 -> 75100; third round e=60 -> 75000.
- Handshake: sample_i held high continuously -> rounds back-to-back every 3*N_CH+1 cycles. A pulse during busy_o is ignored; busy_o is low in DONE.
- Enable/reset: enable_i=0 round -> all duties 75000 and a following round has d=0. Assert rst_n=0 during MAC of ch1 -> duties=75000, busy_o=0, no done_o.
